// File: rtl/mdu.sv
// mdu: iterative multiply/divide unit holding the MIPS HI/LO registers.
//
// Executes MULT, MULTU, DIV and DIVU with one result bit per cycle.
// MTHI/MTLO write HI/LO when the unit is idle. MFHI/MFLO read HI/LO directly.
//
// State table
//   state | meaning
//   IDLE  | waiting for start; moves to HI/LO honoured
//   CALC  | WIDTH iteration cycles, count 0..WIDTH-1
//   FIX   | sign correction; HI/LO loaded at the exit edge
//   DONE  | done=1 for one cycle; moves and a new start are accepted
//
// Ports
//   clk    : clock, rising edge
//   reset  : synchronous, active-high
//   start  : launch an operation (ignored while busy)
//   op     : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   A, B   : rs / rt operands, sampled with start
//   mthi   : write A into HI (IDLE/DONE only)
//   mtlo   : write A into LO (IDLE/DONE only)
//   busy   : high in CALC and FIX
//   done   : one-cycle pulse; HI/LO hold the new result
//   HI, LO : architectural HI/LO registers
module mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;       // product, or quotient bits in the low word
  logic [WIDTH-1:0]   rem;       // partial remainder (always below divisor)
  logic [WIDTH-1:0]   addend;    // multiplicand magnitude or divisor magnitude
  logic [WIDTH-1:0]   a_raw;     // A as launched, for the divide-by-zero result
  logic               is_div;
  logic               neg;       // sign(A) xor sign(B), signed ops only
  logic               rem_neg;   // sign(A), signed ops only
  logic               div_zero;

  logic               idle_or_done;
  logic               launch;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ok;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (start) state_next = S_CALC;
      S_CALC: if (count == LAST) state_next = S_FIX;
      S_FIX:  state_next = S_DONE;
      S_DONE: state_next = start ? S_CALC : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs (decoded from the state register only) ----------------
  always_comb begin
    busy = (state == S_CALC) || (state == S_FIX);
    done = (state == S_DONE);
  end

  // ---------------- datapath combinational ----------------
  always_comb begin
    idle_or_done = (state == S_IDLE) || (state == S_DONE);
    launch       = start && idle_or_done;

    // op[0]=0 selects the signed variants; 0x80000000 negates to itself,
    // which read as unsigned is the required 2^31 magnitude.
    a_neg = ~op[0] & A[WIDTH-1];
    b_neg = ~op[0] & B[WIDTH-1];
    a_mag = a_neg ? -A : A;
    b_mag = b_neg ? -B : B;

    // Shift-add: add multiplicand to the upper word when the current
    // multiplier bit (acc[0]) is set, then shift the whole accumulator right.
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    mul_next = acc[0] ? {mul_sum, acc[WIDTH-1:1]}
                      : {1'b0, acc[2*WIDTH-1:WIDTH], acc[WIDTH-1:1]};

    // Restoring division: bring in the next dividend bit, trial-subtract.
    div_shift = {rem, acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, addend};
    div_ok    = ~div_diff[WIDTH];

    prod_fix = neg ? -acc : acc;
    quo_fix  = div_zero ? '1    : (neg     ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
    rem_fix  = div_zero ? a_raw : (rem_neg ? -rem            : rem);
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      acc      <= '0;
      rem      <= '0;
      addend   <= '0;
      a_raw    <= '0;
      is_div   <= 1'b0;
      neg      <= 1'b0;
      rem_neg  <= 1'b0;
      div_zero <= 1'b0;
      HI       <= '0;
      LO       <= '0;
    end else begin
      if (launch) begin
        count    <= '0;
        is_div   <= op[1];
        neg      <= a_neg ^ b_neg;
        rem_neg  <= a_neg;
        div_zero <= (B == '0);
        a_raw    <= A;
        rem      <= '0;
        if (op[1]) begin
          addend <= b_mag;
          acc    <= {{WIDTH{1'b0}}, a_mag};
        end else begin
          addend <= a_mag;
          acc    <= {{WIDTH{1'b0}}, b_mag};
        end
      end else if (state == S_CALC) begin
        count <= count + 1'b1;
        if (is_div) begin
          acc[WIDTH-1:0] <= {acc[WIDTH-2:0], div_ok};
          rem            <= div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        end else begin
          acc <= mul_next;
        end
      end

      // FIX and the move window never overlap, so the result and a move
      // cannot collide on the same edge.
      if (state == S_FIX) begin
        if (is_div) begin
          HI <= rem_fix;
          LO <= quo_fix;
        end else begin
          HI <= prod_fix[2*WIDTH-1:WIDTH];
          LO <= prod_fix[WIDTH-1:0];
        end
      end else if (idle_or_done) begin
        if (mthi) HI <= A;
        if (mtlo) LO <= A;
      end
    end
  end

endmodule

// File: doc/mdu.md
# mdu

Iterative multiply/divide unit for the MIPS datapath. It executes MULT, MULTU, DIV and DIVU beside the combinational ALU and holds the architectural HI/LO registers. MFHI/MFLO read these registers and MTHI/MTLO write them. The unit takes operands through a start/busy/done handshake so the pipeline can stall until results are ready.

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO width; only 32 is supported, and the iteration count equals WIDTH.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  launches an operation; sampled only when the unit is not busy.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
- A  in  32  rs operand (multiplicand / dividend).
- B  in  32  rt operand (multiplier / divisor).
- mthi  in  1  write A into HI.
- mtlo  in  1  write A into LO.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse; HI/LO hold the new result in this cycle.
- HI  out  32  HI register (product high word / remainder).
- LO  out  32  LO register (product low word / quotient).

## Operation
- States: IDLE, CALC, FIX, DONE.
  - IDLE: waits for start.
  - CALC: 32 iteration cycles, counter 0..31.
  - FIX: one cycle for sign correction.
  - DONE: one cycle, done=1.
- Transitions:
  - IDLE/DONE + start go to CALC.
  - DONE without start goes to IDLE.
  - CALC goes to FIX when the counter reaches 31.
  - FIX goes to DONE.
- busy=1 in CALC and FIX only.
- Launch (start accepted): latch op and sign flags, and latch magnitudes.
  - Signed ops (MULT, DIV): magnitude = two's-complement absolute value of each operand; 0x80000000 is kept as unsigned 2^31.
  - Unsigned ops: operands taken as-is.
- Multiply: shift-add, one multiplier bit per CALC cycle, into a 64-bit accumulator.
- Divide: restoring division, one quotient bit per CALC cycle, with a 33-bit partial remainder.
- FIX, signed ops:
  - Product is negated if sign(A) XOR sign(B).
  - Quotient is negated if sign(A) XOR sign(B).
  - Remainder takes the sign of A.
- Divide by zero (B==0), signed or unsigned: LO=0xFFFFFFFF, HI=A as launched. Full latency still applies; there is no early exit.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. This falls out of the magnitude path.
- HI/LO are written at the FIX→DONE edge and hold their value until the next result, an MTHI/MTLO, or reset.
- mthi/mtlo:
  - Honoured in IDLE and DONE; write at the next edge.
  - Ignored while busy.
  - Both asserted together: both registers are written with A.
- mthi/mtlo with start in the same cycle: the move write happens, the operation is also launched, and its result overwrites HI/LO at completion.
- start while busy: ignored, with no queuing. The controller must hold start until busy=0.
- A, B and op are don't-care after the launch edge.

## Timing
- Reset: state=IDLE, busy=0, done=0, HI=0, LO=0, counter=0.
- Reset asserted mid-operation aborts the operation at the next edge and applies all of the above; no partial result reaches HI/LO.
- Latency, with start sampled at edge 0:
  - busy=1 in cycles 1..33 (32 CALC + 1 FIX).
  - done=1 and the new HI/LO are visible in cycle 34.
  - busy=0 in cycle 34.
- Back-to-back: start in the DONE cycle (34) launches the next op. busy is 1 in cycle 35 and done is 0. Throughput is one op per 34 cycles.
- done is never high in two consecutive cycles.
- busy and done are registered outputs, with no combinational path from inputs.
- MFHI/MFLO read HI/LO directly. The reader must not read during busy; there is no forwarding.

## Test plan
- Reset and latency: after reset, HI=LO=0 and busy=done=0. Launch MULTU 6×7 → busy high for exactly 33 cycles, done in cycle 34, HI=0, LO=0x0000002A.
- Signed multiply:
  - MULT 0xFFFFFFFD×0x00000007 → HI=0xFFFFFFFF, LO=0xFFFFFFEB.
  - MULTU 0xFFFFFFFF×0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- Divide and corners:
  - DIV 0xFFFFFFF9/0x00000002 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
  - DIVU 0x64/0 → LO=0xFFFFFFFF, HI=0x64.
- Move and collision rules:
  - mthi A=0x1234 in IDLE → HI=0x1234 next cycle.
  - mtlo during busy → LO unchanged.
  - start during busy → ignored, with only one done pulse.
  - Back-to-back start in the DONE cycle → second result correct at cycle 68.
- Reset mid-operation: launch DIVU 100/7, assert reset in cycle 10 → next cycle busy=0, done=0, HI=LO=0. No done pulse follows, and a fresh op then completes normally.
- Random regression: 1000 random A/B/op pairs compared against a 64-bit reference model, with HI/LO checked on each done pulse.
